// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ   = 3;
    localparam int DEF_MAX_PKT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    logic found;

    // Outer loop walks distance from ptr; the inner loop maps that distance to a bit.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    win[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter merging N byte streams onto one UART transmitter.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int MAX_PKT = DEF_MAX_PKT
) (
    input  logic               osc_clk,
    input  logic               osc_reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               pkt_trunc
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_PKT);
    localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);

    arb_state_t       state_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [PW-1:0]    rr_ptr_reg;
    logic [CW-1:0]    byte_cnt_reg;
    logic             pkt_trunc_reg;

    logic [N_REQ-1:0] win;
    logic [PW-1:0]    owner_idx;
    logic             owner_last;
    logic             handshake;
    logic [CW-1:0]    byte_cnt_next;
    logic [PW-1:0]    rr_ptr_next;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_reg),
        .win (win)
    );

    // The one-hot grant steers data and last straight through with no added latency.
    always_comb begin
        owner_idx  = '0;
        tx_data    = '0;
        owner_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_reg[i]) begin
                owner_idx  = PW'(i);
                tx_data    = req_data[8*i +: 8];
                owner_last = req_last[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_reg[gi] & tx_ready & ~osc_reset;
        end
    endgenerate

    assign tx_valid      = (|(grant_reg & req_valid)) & ~osc_reset;
    assign handshake     = tx_valid & tx_ready;
    assign byte_cnt_next = byte_cnt_reg + 1'b1;
    assign rr_ptr_next   = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            byte_cnt_reg  <= '0;
            pkt_trunc_reg <= 1'b0;
        end else begin
            pkt_trunc_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        state_reg    <= XFER;
                        grant_reg    <= win;
                        byte_cnt_reg <= '0;
                    end
                end
                XFER: begin
                    if (handshake) begin
                        byte_cnt_reg <= byte_cnt_next;
                        // A last byte landing exactly on the limit is a normal completion.
                        if (owner_last || (byte_cnt_next == CNT_LIMIT)) begin
                            state_reg     <= IDLE;
                            grant_reg     <= '0;
                            rr_ptr_reg    <= rr_ptr_next;
                            pkt_trunc_reg <= ~owner_last;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant     = grant_reg;
    assign pkt_trunc = pkt_trunc_reg;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, meaning the number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter MAX_PKT, default 16, meaning the maximum number of bytes per grant before the grant is forcibly released.
REQ-003 SHALL have port osc_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port osc_reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, N_REQ bits: per-requester byte valid.
REQ-006 SHALL have port req_data, input, N_REQ*8 bits: per-requester byte, requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, N_REQ bits: marks the final byte of a packet.
REQ-008 SHALL have port req_ready, output, N_REQ bits: per-requester byte accepted when ANDed with req_valid.
REQ-009 SHALL have port tx_valid, output, 1 bit: byte valid toward the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8 bits: byte toward the UART transmitter.
REQ-011 SHALL have port tx_ready, input, 1 bit: UART transmitter accepts the byte.
REQ-012 SHALL have port grant, output, N_REQ bits: one-hot current owner, all-zero when idle.
REQ-013 SHALL have port pkt_trunc, output, 1 bit: one-cycle pulse when a grant is released by MAX_PKT rather than by req_last.

Function
REQ-014 SHALL implement two states: IDLE and XFER.
REQ-015 IDLE: grant=0; req_ready=0; tx_valid=0.
REQ-016 IDLE -> XFER when any req_valid=1: the winner SHALL be the first set req_valid bit searching upward (with wrap) from rr_ptr; grant is registered and visible the next cycle.
REQ-017 XFER: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, and all other req_ready bits=0; this path SHALL be combinational (zero added latency).
REQ-018 The handshake is tx_valid & tx_ready; each handshake SHALL increment byte_cnt, an unsigned counter of width clog2(MAX_PKT+1), which is cleared on entry to XFER.
REQ-019 On a handshake with req_last[g]=1, the block SHALL move XFER -> IDLE and set rr_ptr=(g+1) mod N_REQ.
REQ-020 On a handshake with req_last[g]=0 and byte_cnt+1==MAX_PKT, the block SHALL move XFER -> IDLE, set rr_ptr=(g+1) mod N_REQ, and pulse pkt_trunc for the following cycle.
REQ-021 When req_last and the MAX_PKT limit coincide on the same handshake, the packet SHALL be treated as normally completed (no pkt_trunc).
REQ-022 If the owner drops req_valid mid-packet, the grant SHALL be held indefinitely with tx_valid=0.
REQ-023 Between consecutive grants there SHALL be exactly one IDLE cycle, so back-to-back packets have a one-cycle tx_valid bubble.
REQ-024 Changes to req_valid of non-owners SHALL have no effect during XFER.
REQ-025 A packet from a single requester with no contention SHALL reach tx_valid one cycle after req_valid first rises in IDLE.

Reset
REQ-026 While osc_reset=1 at a clock edge, the block SHALL enter IDLE, clear grant, rr_ptr, byte_cnt and pkt_trunc, and force req_ready=0 and tx_valid=0, including when reset is asserted mid-packet (the partial packet is abandoned).
REQ-027 After osc_reset deasserts, the first arbitration SHALL start from requester 0.

Structure
REQ-028 Package uart_arb_pkg SHALL hold the state enum (IDLE, XFER) and the default N_REQ and MAX_PKT constants.
REQ-029 The round-robin picker SHALL be a combinational sub-module, rr_pick, with inputs req and ptr and a one-hot output win; uart_tx_arbiter instantiates it once.

Verification
REQ-030 Reset mid-packet: requester 1 owns the bus after sending 3 of 5 bytes; assert osc_reset for 1 cycle -> grant=0, tx_valid=0 next cycle; then req_valid=3'b110 -> grant=3'b010.
REQ-031 Round robin: all three requesters hold valid 2-byte packets, tx_ready=1 -> grant sequence 001, 010, 100, 001, with one tx_valid=0 cycle between packets.
REQ-032 Truncation: requester 2 sends 20 bytes with req_last only on byte 20 -> grant drops after 16 handshakes, pkt_trunc pulses once; the next grant goes to requester 0 if it is valid.
REQ-033 Backpressure: tx_ready toggles 1,0,1,0 during a 4-byte packet from requester 0 -> req_ready[0] mirrors tx_ready; bytes 0xA1..0xA4 appear on tx_data in order, none lost or duplicated.
REQ-034 Coincident limit: a 16-byte packet with req_last on byte 16 -> release with pkt_trunc=0.
REQ-035 Owner stall: requester 1 drops req_valid for 10 cycles mid-packet while requester 0 is valid -> grant stays 3'b010, tx_valid=0 for those 10 cycles.
